bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single RAM port.
// Each master posts a single read or write request. The arbiter accepts
// one master at a time and drives the RAM's four-phase handshake:
//   pin up -> ACK up -> pin down -> ACK down -> done.
// A watchdog aborts any handshake that stalls for TIMEOUT cycles.
// RAM_ACK / RAM_READ_PIN / RAM_WRITE_PIN select the bit positions used
// inside the 32-bit RAM control and status words.
module bus_arbiter #(
   parameter int unsigned TIMEOUT       = 1024,
   parameter int unsigned RAM_ACK       = 0,
   parameter int unsigned RAM_READ_PIN  = 0,
   parameter int unsigned RAM_WRITE_PIN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m1_req,
   input  logic        m0_we,
   input  logic        m1_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m0_wdata,
   input  logic [31:0] m1_wdata,
   output logic        m0_gnt,
   output logic        m1_gnt,
   output logic        m0_done,
   output logic        m1_done,
   output logic [31:0] m0_rdata,
   output logic [31:0] m1_rdata,
   input  logic [31:0] ram_ctrl_from_hw,
   output logic [31:0] ram_ctrl_to_hw,
   output logic [31:0] addr,
   input  logic [31:0] data_from_hw,
   output logic [31:0] data_to_hw,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      WAIT_REL
   } state_t;

   localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

   state_t      r_state;
   logic        r_owner;       // master being served: 0 = m0, 1 = m1
   logic        r_last;        // master served most recently: 0 = m0, 1 = m1
   logic        r_we;          // latched direction of the transaction in flight
   logic [31:0] r_cnt;         // cycles spent waiting on the RAM handshake
   logic [31:0] r_ctrl;
   logic [31:0] r_addr;
   logic [31:0] r_data_to_hw;
   logic [31:0] r_m0_rdata;
   logic [31:0] r_m1_rdata;
   logic        r_m0_gnt;
   logic        r_m1_gnt;
   logic        r_m0_done;
   logic        r_m1_done;
   logic        r_busy;
   logic        r_timeout_err;

   logic        w_any_req;
   logic        w_pick_m1;
   logic        w_we;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_ack;
   logic [31:0] w_issue_ctrl;
   logic [31:0] w_cnt_next;
   logic        w_timeout;
   logic        w_unused_status;

   // Only one status bit is consumed; the remaining bits are folded here on purpose.
   assign w_unused_status = ^ram_ctrl_from_hw;

   // On a tie, the master that did not go last wins.
   // A lone requester always wins.
   assign w_any_req = m0_req | m1_req;
   assign w_pick_m1 = m1_req & (~m0_req | ~r_last);
   assign w_we      = w_pick_m1 ? m1_we    : m0_we;
   assign w_addr    = w_pick_m1 ? m1_addr  : m0_addr;
   assign w_wdata   = w_pick_m1 ? m1_wdata : m0_wdata;
   assign w_ack     = ram_ctrl_from_hw[RAM_ACK];

   // The watchdog fires on the edge at which the wait count would reach TIMEOUT.
   assign w_cnt_next = r_cnt + 32'd1;
   assign w_timeout  = (r_state != IDLE) && (w_cnt_next == TIMEOUT);

   // Build the control word for a new transaction: exactly one of READ/WRITE pins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_issue_ctrl                = '0;
      w_issue_ctrl[RAM_READ_PIN]  = ~w_we;
      w_issue_ctrl[RAM_WRITE_PIN] = w_we;
   end

   // Arbitration and RAM handshake FSM; every output is a register written here.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so all registers update together on the edge.
      if (!rst) begin
         r_state       <= IDLE;
         r_owner       <= 1'b0;
         r_last        <= 1'b1;
         r_we          <= 1'b0;
         r_cnt         <= '0;
         r_ctrl        <= '0;
         r_addr        <= '0;
         r_data_to_hw  <= '0;
         r_m0_rdata    <= '0;
         r_m1_rdata    <= '0;
         r_m0_gnt      <= 1'b0;
         r_m1_gnt      <= 1'b0;
         r_m0_done     <= 1'b0;
         r_m1_done     <= 1'b0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_m0_gnt  <= 1'b0;
         r_m1_gnt  <= 1'b0;
         r_m0_done <= 1'b0;
         r_m1_done <= 1'b0;

         if (w_timeout) begin
            r_ctrl        <= '0;
            r_timeout_err <= 1'b1;
            r_last        <= r_owner;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
            if (r_owner) begin
               r_m1_rdata <= ABORT_RDATA;
               r_m1_done  <= 1'b1;
            end else begin
               r_m0_rdata <= ABORT_RDATA;
               r_m0_done  <= 1'b1;
            end
         end else begin
            case (r_state)
               IDLE: begin
                  // A RAM still holding ACK from a previous cycle blocks any new issue.
                  if (w_any_req && !w_ack) begin
                     r_owner      <= w_pick_m1;
                     r_we         <= w_we;
                     r_addr       <= w_addr;
                     r_data_to_hw <= w_we ? w_wdata : 32'd0;
                     r_ctrl       <= w_issue_ctrl;
                     r_cnt        <= '0;
                     r_busy       <= 1'b1;
                     r_m0_gnt     <= ~w_pick_m1;
                     r_m1_gnt     <= w_pick_m1;
                     r_state      <= WAIT_ACK;
                  end
               end

               WAIT_ACK: begin
                  r_cnt <= w_cnt_next;
                  if (w_ack) begin
                     r_ctrl <= '0;
                     if (!r_we) begin
                        if (r_owner) r_m1_rdata <= data_from_hw;
                        else         r_m0_rdata <= data_from_hw;
                     end
                     r_state <= WAIT_REL;
                  end
               end

               WAIT_REL: begin
                  r_cnt <= w_cnt_next;
                  if (!w_ack) begin
                     r_m0_done <= ~r_owner;
                     r_m1_done <= r_owner;
                     r_last    <= r_owner;
                     r_busy    <= 1'b0;
                     r_state   <= IDLE;
                  end
               end

               default: begin
                  r_ctrl  <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign m0_gnt         = r_m0_gnt;
   assign m1_gnt         = r_m1_gnt;
   assign m0_done        = r_m0_done;
   assign m1_done        = r_m1_done;
   assign m0_rdata       = r_m0_rdata;
   assign m1_rdata       = r_m1_rdata;
   assign ram_ctrl_to_hw = r_ctrl;
   assign addr           = r_addr;
   assign data_to_hw     = r_data_to_hw;
   assign busy           = r_busy;
   assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter.
// A transaction-level reference model predicts, for each transaction:
//   - the winning master,
//   - the done cycle,
//   - the returned read data,
//   - the sticky error flag.
// These are derived from the ACK timing the bench applies.
module tb_bus_arbiter;

   localparam int unsigned T      = 8;
   localparam logic [31:0] RD_PIN = 32'h1;
   localparam logic [31:0] WR_PIN = 32'h2;
   localparam logic [31:0] ACK    = 32'h1;

   logic        clk;
   logic        rst;
   logic        m0_req, m1_req, m0_we, m1_we;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_done, m1_done;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] ram_ctrl_from_hw, ram_ctrl_to_hw, addr, data_from_hw, data_to_hw;
   logic        busy, timeout_err;

   bus_arbiter #(.TIMEOUT(T)) dut (
      .clk              (clk),
      .rst              (rst),
      .m0_req           (m0_req),
      .m1_req           (m1_req),
      .m0_we            (m0_we),
      .m1_we            (m1_we),
      .m0_addr          (m0_addr),
      .m1_addr          (m1_addr),
      .m0_wdata         (m0_wdata),
      .m1_wdata         (m1_wdata),
      .m0_gnt           (m0_gnt),
      .m1_gnt           (m1_gnt),
      .m0_done          (m0_done),
      .m1_done          (m1_done),
      .m0_rdata         (m0_rdata),
      .m1_rdata         (m1_rdata),
      .ram_ctrl_from_hw (ram_ctrl_from_hw),
      .ram_ctrl_to_hw   (ram_ctrl_to_hw),
      .addr             (addr),
      .data_from_hw     (data_from_hw),
      .data_to_hw       (data_to_hw),
      .busy             (busy),
      .timeout_err      (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A single transaction:
   //   - a = cycle (after issue) at which ACK is first seen,
   //   - ACK is held for h cycles.
   typedef struct {
      logic        r0, r1, we0, we1;
      logic [31:0] addr0, addr1, wd0, wd1, rd;
      int          a, h;
      logic        exp_m1;
      int          exp_end;
      logic [31:0] exp_rdata;
      logic        exp_to;
   } vec_t;

   int          n_cmp;
   int          n_bad;
   logic        mdl_last;
   logic [31:0] mdl_rdata [2];
   logic        mdl_to;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b0;
      {m0_req, m1_req, m0_we, m1_we} = '0;
      {m0_addr, m1_addr, m0_wdata, m1_wdata} = '0;
      ram_ctrl_from_hw = '0;
      data_from_hw     = '0;
      tick();
      check("rst_ctrl",  ram_ctrl_to_hw, 32'd0);
      check("rst_addr",  addr,           32'd0);
      check("rst_wdata", data_to_hw,     32'd0);
      check("rst_rd0",   m0_rdata,       32'd0);
      check("rst_rd1",   m1_rdata,       32'd0);
      check("rst_flags", 32'({m0_gnt, m1_gnt, m0_done, m1_done, busy, timeout_err}), 32'd0);
      rst          = 1'b1;
      mdl_last     = 1'b1;
      mdl_rdata[0] = '0;
      mdl_rdata[1] = '0;
      mdl_to       = 1'b0;
   endtask

   // Drive one request through a complete handshake.
   // All cycle-by-cycle outputs are checked against the record's expectations.
   task automatic run_txn(input vec_t v);
      logic        w;
      logic        we;
      logic [31:0] ctrl_exp, addr_exp, dat_exp, pair;
      w        = v.exp_m1;
      pair     = w ? 32'd2 : 32'd1;
      m0_req   = v.r0;    m1_req   = v.r1;
      m0_we    = v.we0;   m1_we    = v.we1;
      m0_addr  = v.addr0; m1_addr  = v.addr1;
      m0_wdata = v.wd0;   m1_wdata = v.wd1;
      ram_ctrl_from_hw = '0;
      data_from_hw     = v.rd;
      tick();
      we       = w ? v.we1 : v.we0;
      addr_exp = w ? v.addr1 : v.addr0;
      dat_exp  = we ? (w ? v.wd1 : v.wd0) : 32'd0;
      ctrl_exp = we ? WR_PIN : RD_PIN;
      check("gnt",       32'({m1_gnt, m0_gnt}), pair);
      check("busy_issue", 32'(busy),            32'd1);
      check("addr_issue", addr,                 addr_exp);
      check("wdata_issue", data_to_hw,          dat_exp);
      check("pin_issue", ram_ctrl_to_hw,        ctrl_exp);
      // Requester changes its mind after the grant; the latched transaction must not notice.
      m0_req   = 1'b0;          m1_req   = 1'b0;
      m0_we    = 1'($urandom);  m1_we    = 1'($urandom);
      m0_addr  = $urandom;      m1_addr  = $urandom;
      m0_wdata = $urandom;      m1_wdata = $urandom;
      for (int k = 1; k <= v.exp_end; k++) begin
         ram_ctrl_from_hw = (k >= v.a && k < v.a + v.h) ? ACK : 32'd0;
         tick();
         check("pins", ram_ctrl_to_hw, (k < v.a && k < v.exp_end) ? ctrl_exp : 32'd0);
         if (k < v.exp_end) begin
            check("addr_hold",  addr,       addr_exp);
            check("wdata_hold", data_to_hw, dat_exp);
         end
         check("done",      32'({m1_done, m0_done}), (k == v.exp_end) ? pair : 32'd0);
         check("gnt_quiet", 32'({m1_gnt, m0_gnt}),   32'd0);
         check("busy",      32'(busy),               32'(k < v.exp_end));
      end
      ram_ctrl_from_hw = '0;
      mdl_rdata[w] = v.exp_rdata;
      mdl_to       = mdl_to | v.exp_to;
      mdl_last     = w;
      check("rdata0",      m0_rdata,          mdl_rdata[0]);
      check("rdata1",      m1_rdata,          mdl_rdata[1]);
      check("timeout_err", 32'(timeout_err), 32'(mdl_to));
   endtask

   vec_t tbl [6];
   vec_t rv;
   int   order [$];
   int   cyc;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      // Record fields, in order:
      //   r0 r1 we0 we1 addr0 addr1 wd0 wd1 rd a h exp_m1 exp_end exp_rdata exp_to
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,  32'h999, 32'h0,    32'h55,   3, 1, 1'b0, 4, 32'h55,       1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 32'h20, 32'h0,   32'hABCD, 32'hFFFF, 2, 2, 1'b1, 4, 32'h0,        1'b0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h44, 32'h0,   32'h5,    32'h1234, 1, 1, 1'b0, 2, 32'h1234,     1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h54, 32'h7,   32'h0,    32'h77,   5, 2, 1'b1, 7, 32'h77,       1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h60, 32'h0,  32'h0,   32'h0,    32'h88,   9, 1, 1'b0, 8, 32'hDEADBEEF, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h70, 32'h0,   32'h1,    32'h99,   6, 2, 1'b1, 8, 32'hDEADBEEF, 1'b1};

      do_reset();
      for (int i = 0; i < 6; i++) run_txn(tbl[i]);

      // The timeout flag stays set while the arbiter sits idle.
      repeat (3) tick();
      check("err_sticky", 32'(timeout_err), 32'd1);

      // ACK held high while idle blocks the grant until it drops.
      ram_ctrl_from_hw = ACK;
      m0_req  = 1'b1;
      m0_we   = 1'b0;
      m0_addr = 32'h99;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ack_block_gnt",  32'({m1_gnt, m0_gnt}), 32'd0);
         check("ack_block_busy", 32'(busy),             32'd0);
         check("ack_block_pins", ram_ctrl_to_hw,        32'd0);
      end
      ram_ctrl_from_hw = '0;
      tick();
      check("ack_free_gnt", 32'({m1_gnt, m0_gnt}), 32'd1);
      check("ack_free_pin", ram_ctrl_to_hw,        RD_PIN);
      m0_req = 1'b0;
      tick();

      // Reset during WAIT_ACK drops everything on that edge, with no done pulse.
      rst = 1'b0;
      tick();
      check("mid_rst_pins", ram_ctrl_to_hw, 32'd0);
      check("mid_rst_addr", addr,           32'd0);
      check("mid_rst_flags", 32'({m0_gnt, m1_gnt, m0_done, m1_done, busy, timeout_err}), 32'd0);
      rst          = 1'b1;
      mdl_last     = 1'b1;
      mdl_rdata[0] = '0;
      mdl_rdata[1] = '0;
      mdl_to       = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_quiet", 32'({m0_gnt, m1_gnt, m0_done, m1_done, busy}), 32'd0);
      end

      // Both masters hold their requests; service must alternate m0, m1, m0, m1.
      m0_req  = 1'b1;  m1_req  = 1'b1;
      m0_we   = 1'b0;  m1_we   = 1'b0;
      m0_addr = 32'hA0; m1_addr = 32'hB0;
      data_from_hw = 32'h5A5A;
      cyc = 0;
      while (order.size() < 4 && cyc < 200) begin
         ram_ctrl_from_hw = (ram_ctrl_to_hw != 0) ? ACK : 32'd0;
         tick();
         cyc++;
         check("gnt_excl",  32'(m0_gnt & m1_gnt),   32'd0);
         check("done_excl", 32'(m0_done & m1_done), 32'd0);
         if (m0_gnt) order.push_back(0);
         if (m1_gnt) order.push_back(1);
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      check("rr_count", 32'(order.size()), 32'd4);
      for (int i = 0; i < order.size(); i++) check("rr_order", 32'(order[i]), 32'(i % 2));
      cyc = 0;
      while (busy && cyc < 50) begin
         ram_ctrl_from_hw = (ram_ctrl_to_hw != 0) ? ACK : 32'd0;
         tick();
         cyc++;
      end
      ram_ctrl_from_hw = '0;
      check("rr_drain", 32'(busy), 32'd0);

      // Randomized transactions against the reference model.
      do_reset();
      for (int n = 0; n < 60; n++) begin
         logic [1:0] sel;
         logic       w;
         logic       we;
         sel      = 2'($urandom_range(1, 3));
         rv.r0    = sel[0];
         rv.r1    = sel[1];
         rv.we0   = 1'($urandom);
         rv.we1   = 1'($urandom);
         rv.addr0 = $urandom;
         rv.addr1 = $urandom;
         rv.wd0   = $urandom;
         rv.wd1   = $urandom;
         rv.rd    = $urandom;
         rv.a     = int'($urandom_range(1, 9));
         rv.h     = int'($urandom_range(1, 3));
         w  = (rv.r0 && rv.r1) ? ~mdl_last : rv.r1;
         we = w ? rv.we1 : rv.we0;
         rv.exp_m1    = w;
         rv.exp_to    = (rv.a + rv.h >= int'(T));
         rv.exp_end   = rv.exp_to ? int'(T) : rv.a + rv.h;
         rv.exp_rdata = rv.exp_to ? 32'hDEADBEEF : (we ? mdl_rdata[w] : rv.rd);
         run_txn(rv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
